id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. It sits directly downstream of the register file and captures the regfile read ports (read_d1/read_d2) together with the decoded instruction fields.
- It performs three jobs:
  - Write-back bypass. The regfile has no write-through, so a same-cycle write-back is not visible on its read ports; this block covers that case.
  - Load-use hazard detection, with bubble insertion.
  - Registered forwarding selects for the EX-stage operand muxes.

Parameters:
CTRL_W, 8, width of the opaque control bundle passed from decode to EX, excluding regwrite/memread.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_rs  in  5  source register 1 index (drives regfile read_r1)
id_rt  in  5  source register 2 index (drives regfile read_r2)
id_dst  in  5  destination register index, already muxed rt/rd/31
id_regwrite  in  1  instruction writes a register
id_memread  in  1  instruction is a load
id_ctrl  in  CTRL_W  remaining decoded control
id_imm  in  32  sign/zero-extended immediate
id_pc4  in  32  PC+4
read_d1  in  32  regfile read data for id_rs
read_d2  in  32  regfile read data for id_rt
mem_regwrite  in  1  EX/MEM instruction writes a register
mem_dst  in  5  EX/MEM destination register
wb_regwrite  in  1  MEM/WB instruction writes the regfile this cycle
wb_dst  in  5  MEM/WB destination register
wb_data  in  32  MEM/WB write data
hold  in  1  global freeze (e.g. memory wait)
flush  in  1  squash decode and ID/EX contents (taken branch/jump resolved in EX)
stall  out  1  freeze PC and IF/ID (combinational)
ex_valid  out  1  ID/EX holds a valid instruction
ex_rs, ex_rt, ex_dst  out  5 each  registered register indices
ex_regwrite, ex_memread  out  1 each  registered control; forced 0 when ex_valid=0
ex_ctrl  out  CTRL_W  registered control bundle
ex_a, ex_b  out  32 each  registered operands after WB bypass
ex_imm, ex_pc4  out  32 each  registered immediate / PC+4
ex_fwd_a, ex_fwd_b  out  2 each  EX mux select: 00 = ex_a/ex_b, 01 = EX/MEM result, 10 = MEM/WB result

Behaviour:
- Reset (async, immediate): every registered output is 0, including ex_valid, ex_regwrite, ex_memread and ex_fwd_*.
- Load-use hazard (combinational): lu = ex_valid & ex_memread & (ex_dst != 0) & id_valid & ((ex_dst == id_rs) | (ex_dst == id_rt)).
- Stall output: stall = (lu | hold) & ~flush.
- Register update priority per posedge, highest first:
  - flush: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_fwd_*=00; other fields don't-care. Flush beats hold.
  - hold: all registers keep their value.
  - lu: insert a bubble (same values as the flush case); IF/ID is held upstream via stall.
  - Otherwise, normal load: ex_valid=id_valid; ex_regwrite/ex_memread = id_* & id_valid; all other fields copied from the id_* inputs.
- WB bypass on load: ex_a = wb_data if (wb_regwrite & wb_dst != 0 & wb_dst == id_rs), else read_d1. ex_b uses the same rule with id_rt/read_d2.
- Forwarding selects on load, computed from the pre-edge state. For operand A (B identical with id_rt):
  - ex_fwd_a = 01 if ex_valid & ex_regwrite & ex_dst != 0 & ex_dst == id_rs. The instruction now in EX will be in EX/MEM next cycle.
  - else ex_fwd_a = 10 if mem_regwrite & mem_dst != 0 & mem_dst == id_rs. That instruction will be in MEM/WB next cycle.
  - else 00.
  - The EX/MEM match (01) wins over the MEM/WB match (10).
- Register $0 never bypasses or forwards, and never triggers lu.
- Latency: exactly 1 cycle from a decode input to the ex_* outputs.
- A bubble never causes a forward: ex_regwrite=0 whenever ex_valid=0.
- hold and lu in the same cycle: hold wins; lu is re-evaluated after hold drops.
- id_valid=0 with no flush/hold/lu: ex_valid=0 and ex_regwrite=ex_memread=0 are loaded.
- rst asserted mid-stall or mid-hold: all outputs clear immediately. After release, stall depends only on the inputs.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all ex_* outputs 0 before the next edge; stall=0 with hold=0.
- Normal load: id_rs=3, read_d1=0x11, id_rt=4, read_d2=0x22, id_imm=0xFFFF_FFF0, no hazards -> next cycle ex_a=0x11, ex_b=0x22, ex_imm=0xFFFF_FFF0, ex_fwd_a=ex_fwd_b=00.
- WB bypass: wb_regwrite=1, wb_dst=5, wb_data=0xDEAD_BEEF, id_rs=5, read_d1=0 -> ex_a=0xDEAD_BEEF. Repeat with wb_dst=0 -> ex_a=0.
- Forward priority: ID/EX holds a regwrite to $7 and mem_dst=7 with mem_regwrite=1, id_rt=7 -> ex_fwd_b=01. Remove the ID/EX match -> ex_fwd_b=10.
- Load-use: ID/EX is `lw` to $8, id_rs=8 -> stall=1 for one cycle, then a bubble (ex_valid=0, ex_regwrite=0). Next cycle stall=0 and the dependent instruction loads with ex_fwd_a=10 (given mem_regwrite=1, mem_dst=8).
- Flush vs hold: hold=1 and flush=1 together -> stall=0 and ex_valid=0 next edge. hold=1 alone for 3 cycles -> ex_* unchanged and stall=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use stall and forwarding selects
module id_ex_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       id_pc4,
    input  logic [31:0]       read_d1,
    input  logic [31:0]       read_d2,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_dst,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_dst,
    input  logic [31:0]       wb_data,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_pc4,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b
);

    logic        lu;
    logic        wb_hit_a, wb_hit_b;
    logic [31:0] a_next, b_next;
    logic [1:0]  fwd_a_next, fwd_b_next;

    always_comb begin
        lu = ex_valid & ex_memread & (ex_dst != 5'd0) & id_valid &
             ((ex_dst == id_rs) | (ex_dst == id_rt));
        stall = (lu | hold) & ~flush;

        // The regfile has no write-through, so a same-cycle write-back is patched in here.
        wb_hit_a = wb_regwrite & (wb_dst != 5'd0) & (wb_dst == id_rs);
        wb_hit_b = wb_regwrite & (wb_dst != 5'd0) & (wb_dst == id_rt);
        a_next   = wb_hit_a ? wb_data : read_d1;
        b_next   = wb_hit_b ? wb_data : read_d2;

        // Producer in EX now reaches EX/MEM next cycle, so it takes priority over EX/MEM -> MEM/WB.
        fwd_a_next = 2'b00;
        if (ex_valid & ex_regwrite & (ex_dst != 5'd0) & (ex_dst == id_rs))
            fwd_a_next = 2'b01;
        else if (mem_regwrite & (mem_dst != 5'd0) & (mem_dst == id_rs))
            fwd_a_next = 2'b10;

        fwd_b_next = 2'b00;
        if (ex_valid & ex_regwrite & (ex_dst != 5'd0) & (ex_dst == id_rt))
            fwd_b_next = 2'b01;
        else if (mem_regwrite & (mem_dst != 5'd0) & (mem_dst == id_rt))
            fwd_b_next = 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_dst      <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_ctrl     <= '0;
            ex_a        <= 32'd0;
            ex_b        <= 32'd0;
            ex_imm      <= 32'd0;
            ex_pc4      <= 32'd0;
            ex_fwd_a    <= 2'b00;
            ex_fwd_b    <= 2'b00;
        end else if (flush || (!hold && lu)) begin
            // Bubble: only the control that could cause side effects is cleared.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_fwd_a    <= 2'b00;
            ex_fwd_b    <= 2'b00;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dst      <= id_dst;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread & id_valid;
            ex_ctrl     <= id_ctrl;
            ex_a        <= a_next;
            ex_b        <= b_next;
            ex_imm      <= id_imm;
            ex_pc4      <= id_pc4;
            ex_fwd_a    <= fwd_a_next;
            ex_fwd_b    <= fwd_b_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk, rst;
    logic        id_valid, id_regwrite, id_memread;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [7:0]  id_ctrl;
    logic [31:0] id_imm, id_pc4, read_d1, read_d2;
    logic        mem_regwrite, wb_regwrite, hold, flush;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] wb_data;
    logic        stall, ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
    logic [1:0]  ex_fwd_a, ex_fwd_b;

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.CTRL_W(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_ctrl(id_ctrl), .id_imm(id_imm), .id_pc4(id_pc4), .read_d1(read_d1),
        .read_d2(read_d2), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data), .hold(hold),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, dst;
        logic        rw, mr;
        logic [31:0] imm, d1, d2;
        logic        mrw;
        logic [4:0]  mdst;
        logic        wrw;
        logic [4:0]  wdst;
        logic [31:0] wdata;
        logic        hold, flush;
        logic        e_stall, e_valid, e_rw, e_mr;
        logic [31:0] e_a, e_b;
        logic [1:0]  e_fa, e_fb;
        logic [4:0]  e_dst;
        logic [31:0] e_imm;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] v, rs, rt, dst, rw, mr, imm, d1, d2, mrw, mdst, wrw, wdst, wdata,
        input logic [31:0] hd, fl, es, ev, erw, emr, ea, eb, efa, efb, edst, eimm);
        vec_t t;
        t.v = v[0]; t.rs = rs[4:0]; t.rt = rt[4:0]; t.dst = dst[4:0];
        t.rw = rw[0]; t.mr = mr[0]; t.imm = imm; t.d1 = d1; t.d2 = d2;
        t.mrw = mrw[0]; t.mdst = mdst[4:0]; t.wrw = wrw[0]; t.wdst = wdst[4:0];
        t.wdata = wdata; t.hold = hd[0]; t.flush = fl[0];
        t.e_stall = es[0]; t.e_valid = ev[0]; t.e_rw = erw[0]; t.e_mr = emr[0];
        t.e_a = ea; t.e_b = eb; t.e_fa = efa[1:0]; t.e_fb = efb[1:0];
        t.e_dst = edst[4:0]; t.e_imm = eimm;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_dst = t.dst;
        id_regwrite = t.rw; id_memread = t.mr; id_imm = t.imm;
        read_d1 = t.d1; read_d2 = t.d2; mem_regwrite = t.mrw; mem_dst = t.mdst;
        wb_regwrite = t.wrw; wb_dst = t.wdst; wb_data = t.wdata;
        hold = t.hold; flush = t.flush;
    endtask

    vec_t vecs[15];
    vec_t h;

    initial begin
        rst = 1'b1;
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
        id_ctrl = 8'h00; id_pc4 = 32'h0;

        //       v rs rt dst rw mr imm            d1       d2    mrw md wrw wd wdata        hd fl | st ev rw mr a             b      fa fb dst imm
        vecs[0]  = mk(1, 3, 4, 9, 1, 0, 32'hFFFF_FFF0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h11, 32'h22, 0, 0, 9, 32'hFFFF_FFF0);
        vecs[1]  = mk(1, 5, 6, 10, 0, 0, 1, 0, 32'h66, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 32'h66, 0, 0, 10, 1);
        vecs[2]  = mk(1, 0, 6, 11, 1, 0, 2, 0, 32'h66, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 0, 0, 32'h66, 0, 0, 11, 2);
        vecs[3]  = mk(1, 1, 2, 7, 1, 0, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 2, 0, 7, 3);
        vecs[4]  = mk(1, 3, 7, 12, 1, 0, 4, 3, 32'h77, 1, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 32'h77, 0, 1, 12, 4);
        vecs[5]  = mk(1, 4, 7, 13, 0, 0, 5, 4, 32'h77, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 32'h77, 0, 2, 13, 5);
        vecs[6]  = mk(1, 0, 0, 0, 1, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6);
        vecs[7]  = mk(1, 0, 0, 14, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 14, 7);
        vecs[8]  = mk(1, 14, 2, 15, 1, 0, 8, 32'h140, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 14, 2, 15, 1, 0, 8, 32'h140, 2, 1, 14, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h140, 2, 2, 0, 15, 8);
        vecs[10] = mk(1, 1, 1, 20, 0, 0, 9, 5, 5, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 32'h140, 2, 2, 0, 15, 8);
        vecs[11] = vecs[10];
        vecs[12] = vecs[10];
        vecs[13] = mk(1, 1, 1, 20, 0, 0, 9, 5, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 2, 3, 1, 1, 9, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst ex_valid", 32'(ex_valid), 0);
        chk("rst ex_regwrite", 32'(ex_regwrite), 0);
        chk("rst ex_a", ex_a, 0);
        chk("rst ex_fwd", 32'({ex_fwd_a, ex_fwd_b}), 0);
        chk("rst stall", 32'(stall), 0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            id_pc4 = 32'h100 + 32'(i) * 4;
            id_ctrl = 8'(i);
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d ex_regwrite", i), 32'(ex_regwrite), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d ex_memread", i), 32'(ex_memread), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d ex_fwd_a", i), 32'(ex_fwd_a), 32'(vecs[i].e_fa));
            chk($sformatf("v%0d ex_fwd_b", i), 32'(ex_fwd_b), 32'(vecs[i].e_fb));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
                chk($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
                chk($sformatf("v%0d ex_dst", i), 32'(ex_dst), 32'(vecs[i].e_dst));
                chk($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].e_imm);
            end
        end

        // lw $8 with all fields checked
        @(negedge clk);
        h = mk(1, 2, 3, 8, 1, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(h);
        id_pc4 = 32'h400; id_ctrl = 8'hA5;
        @(posedge clk); #1;
        chk("lw ex_memread", 32'(ex_memread), 1);
        chk("lw ex_pc4", ex_pc4, 32'h400);
        chk("lw ex_ctrl", 32'(ex_ctrl), 32'hA5);
        chk("lw ex_rs/rt", 32'({ex_rs, ex_rt}), 32'({5'd2, 5'd3}));

        // dependent instruction arrives while hold is up: hold wins over lu
        @(negedge clk);
        h = mk(1, 8, 1, 9, 1, 0, 32'h55, 32'h88, 32'h11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(h);
        #1;
        chk("hold+lu stall", 32'(stall), 1);
        @(posedge clk); #1;
        chk("hold+lu ex_valid", 32'(ex_valid), 1);
        chk("hold+lu ex_dst", 32'(ex_dst), 8);
        chk("hold+lu ex_memread", 32'(ex_memread), 1);

        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("lu stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("lu+flush stall", 32'(stall), 0);
        flush = 1'b0;
        @(posedge clk); #1;
        chk("lu bubble ex_valid", 32'(ex_valid), 0);
        chk("lu bubble ex_regwrite", 32'(ex_regwrite), 0);

        @(negedge clk);
        mem_regwrite = 1'b1; mem_dst = 5'd8;
        #1;
        chk("post-lu stall", 32'(stall), 0);
        @(posedge clk); #1;
        chk("post-lu ex_valid", 32'(ex_valid), 1);
        chk("post-lu ex_fwd_a", 32'(ex_fwd_a), 2);
        chk("post-lu ex_a", ex_a, 32'h88);
        chk("post-lu ex_dst", 32'(ex_dst), 9);

        // async reset mid-cycle while holding
        @(negedge clk);
        hold = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst ex_valid", 32'(ex_valid), 0);
        chk("mid rst ex_regwrite", 32'(ex_regwrite), 0);
        chk("mid rst ex_dst", 32'(ex_dst), 0);
        chk("mid rst ex_pc4", ex_pc4, 0);
        chk("mid rst ex_fwd_a", 32'(ex_fwd_a), 0);
        chk("mid rst stall hold", 32'(stall), 1);
        hold = 1'b0;
        #1;
        chk("mid rst stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst stall", 32'(stall), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
